// File: rtl/afifo_pkg.sv
// afifo_pkg: helpers shared by the write- and read-side pointer controllers
// of the asynchronous FIFO.
//   addr_w()   : RAM address width for a given power-of-two depth.
//   bin2gray() : binary to reflected Gray code.
//   gray2bin() : reflected Gray code to binary.
// The code functions work on a PTR_MAX_W-bit argument. Callers zero-extend
// narrower pointers and truncate the result back to their width. Leading
// zeros do not change either conversion, so this is exact for any width up
// to PTR_MAX_W.
package afifo_pkg;

    localparam int PTR_MAX_W = 32;
    localparam int MIN_DEPTH = 4;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter (XOR prefix from the
// MSB down). It is shared by the write-side full controller and the
// read-side empty controller.
// Ports:
//   gray : W-bit Gray-coded input
//   bin  : W-bit binary output
module gray2bin_conv #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the parity of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain pointer and status controller for the
// asynchronous FIFO. It owns the binary write count and the Gray write
// pointer. From the read pointer (already synchronised into w_clk) it
// derives full, occupancy level, almost-full and overflow.
// Ports:
//   w_clk, w_rst : write clock; asynchronous active-high reset
//   wr_en        : client write request
//   wsync_rptr   : read Gray pointer, synchronised into w_clk
//   ovf_clr      : clears sticky overflow (sticky build only)
//   wr_ack       : write accepted this cycle (RAM write enable)
//   waddr        : RAM write address
//   wptr         : registered Gray write pointer to the read domain
//   full         : FIFO full
//   almost_full  : level >= AF_THRESH
//   wr_level     : occupied entries 0..DEPTH (pessimistic)
//   ovf_err      : write attempted while full
// Build option: define WPTR_FULL_OVF_STICKY_EN to make ovf_err sticky until
// ovf_clr. Without it, ovf_err is a one-cycle pulse per rejected write.
module wptr_full_ctrl
    import afifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                         w_clk,
    input  logic                         w_rst,
    input  logic                         wr_en,
    input  logic [addr_w(DEPTH):0]       wsync_rptr,
    input  logic                         ovf_clr,
    output logic                         wr_ack,
    output logic [addr_w(DEPTH)-1:0]     waddr,
    output logic [addr_w(DEPTH):0]       wptr,
    output logic                         full,
    output logic                         almost_full,
    output logic [addr_w(DEPTH):0]       wr_level,
    output logic                         ovf_err
);

    localparam int AW = addr_w(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_THRESH);

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wptr_q, wptr_d;
    logic        full_q, full_d;
    logic        almost_full_q, almost_full_d;
    logic [AW:0] wr_level_q, wr_level_d;
    logic        ovf_err_q, ovf_err_d;
    logic [AW:0] rbin;

    gray2bin_conv #(.W(AW+1)) u_rptr_g2b (
        .gray (wsync_rptr),
        .bin  (rbin)
    );

    // Uses the registered full, so a read arriving in the same cycle as a
    // write-while-full does not rescue that write; the client retries.
    assign wr_ack = wr_en & ~full_q;

    always_comb begin
        wbin_d = wbin_q + (AW+1)'(wr_ack);
        wptr_d = (AW+1)'(bin2gray(PTR_MAX_W'(wbin_d)));
        // Full when the next write pointer is exactly one lap ahead of the
        // read pointer: in Gray code that inverts the top two bits.
        full_d = (wptr_d == {~wsync_rptr[AW:AW-1], wsync_rptr[AW-2:0]});
        // Modulo 2^(AW+1) subtraction keeps the level right across wrap.
        wr_level_d    = wbin_d - rbin;
        almost_full_d = (wr_level_d >= AF_LVL);
`ifdef WPTR_FULL_OVF_STICKY_EN
        // Set has priority over clear.
        ovf_err_d = (wr_en & full_q) | (ovf_err_q & ~ovf_clr);
`else
        ovf_err_d = wr_en & full_q;
`endif
    end

`ifndef WPTR_FULL_OVF_STICKY_EN
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
`endif

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wbin_q        <= '0;
            wptr_q        <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            wr_level_q    <= '0;
            ovf_err_q     <= 1'b0;
        end else begin
            wbin_q        <= wbin_d;
            wptr_q        <= wptr_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            wr_level_q    <= wr_level_d;
            ovf_err_q     <= ovf_err_d;
        end
    end

    assign waddr       = wbin_q[AW-1:0];
    assign wptr        = wptr_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign wr_level    = wr_level_q;
    assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Testbench for wptr_full_ctrl (DEPTH=16, AF_THRESH=14): a directed vector
// table, hand-written corner sequences and a randomized run against a
// count-based reference model.
module tb_wptr_full_ctrl;

`ifdef WPTR_FULL_OVF_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       w_clk;
    logic       w_rst;
    logic       wr_en;
    logic [4:0] wsync_rptr;
    logic       ovf_clr;
    logic       wr_ack;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       ovf_err;

    int n_vec = 0;
    int n_err = 0;

    wptr_full_ctrl #(.DEPTH(16), .AF_THRESH(14)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .wr_en       (wr_en),
        .wsync_rptr  (wsync_rptr),
        .ovf_clr     (ovf_clr),
        .wr_ack      (wr_ack),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .ovf_err     (ovf_err)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    typedef struct {
        logic       we;
        logic [4:0] rp;
        logic       clr;
        logic       ack;
        logic       full;
        logic [4:0] lvl;
        logic [4:0] wptr;
        logic       af;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [4:0] g(input int x);
        int y;
        y = x & 31;
        return 5'((y ^ (y >> 1)) & 31);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic we, input logic [4:0] rp, input logic clr,
                       input logic ack, input logic fl, input int lvl,
                       input logic [4:0] wp, input logic af, input logic ovf);
        vec_t v;
        v.we = we; v.rp = rp; v.clr = clr; v.ack = ack; v.full = fl;
        v.lvl = 5'(lvl); v.wptr = wp; v.af = af; v.ovf = ovf;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Reference model state (counts, not pointers)
    int  m_w, m_r, m_lvl;
    bit  m_full, m_ovf, m_af;

    initial begin
        w_rst = 1'b1; wr_en = 1'b0; wsync_rptr = '0; ovf_clr = 1'b0;

        // ---- reset state
        tick(); tick();
        chk("rst_wptr", wptr, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_lvl", wr_level, 0);
        chk("rst_ovf", ovf_err, 0);
        w_rst = 1'b0;

        // ---- directed table: fill, overflow, clear, release
        for (int i = 0; i < 16; i++)
            add(1, 5'b00000, 0, 1, (i == 15), i + 1, g(i + 1), (i + 1 >= 14), 0);
        for (int i = 0; i < 3; i++)
            add(1, 5'b00000, 0, 0, 1, 16, 5'b11000, 1, 1);
        add(0, 5'b00000, 0, 0, 1, 16, 5'b11000, 1, STICKY);
        add(0, 5'b00000, 1, 0, 1, 16, 5'b11000, 1, 0);
        add(0, 5'b11000, 0, 0, 0, 0, 5'b11000, 0, 0);

        foreach (tbl[k]) begin
            wr_en = tbl[k].we; wsync_rptr = tbl[k].rp; ovf_clr = tbl[k].clr;
            #1;
            chk("tbl_ack", wr_ack, tbl[k].ack);
            tick();
            chk("tbl_full", full, tbl[k].full);
            chk("tbl_lvl", wr_level, tbl[k].lvl);
            chk("tbl_wptr", wptr, tbl[k].wptr);
            chk("tbl_af", almost_full, tbl[k].af);
            chk("tbl_ovf", ovf_err, tbl[k].ovf);
        end
        ovf_clr = 1'b0;

        // ---- wrap: 16 more writes, rptr held at 16 (11000), count wraps to 0
        wsync_rptr = 5'b11000;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            #1;
            chk("wrap_ack", wr_ack, 1);
            tick();
        end
        chk("wrap_wptr", wptr, 0);
        chk("wrap_waddr", waddr, 0);
        chk("wrap_full", full, 1);
        chk("wrap_lvl", wr_level, 16);

        // ---- write while full with read pointer advancing in the same cycle
        wr_en = 1'b1; wsync_rptr = g(17);
        #1;
        chk("same_ack", wr_ack, 0);
        tick();
        chk("same_full", full, 0);
        chk("same_lvl", wr_level, 15);
        chk("same_wptr", wptr, 0);
        chk("same_ovf", ovf_err, 1);
        #1;
        chk("retry_ack", wr_ack, 1);
        tick();
        chk("retry_wptr", wptr, g(1));
        chk("retry_full", full, 1);
        chk("retry_lvl", wr_level, 16);

        // ---- asynchronous reset mid-burst
        wr_en = 1'b0; wsync_rptr = '0; ovf_clr = 1'b1;
        w_rst = 1'b1; tick(); w_rst = 1'b0; ovf_clr = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_lvl", wr_level, 5);
        #3;
        w_rst = 1'b1;
        #1;
        chk("arst_wptr", wptr, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_lvl", wr_level, 0);
        chk("arst_full", full, 0);
        chk("arst_af", almost_full, 0);
        chk("arst_ovf", ovf_err, 0);
        tick();
        wr_en = 1'b0;
        w_rst = 1'b0;

        // ---- randomized run against the count model
        m_w = 0; m_r = 0; m_lvl = 0; m_full = 0; m_ovf = 0; m_af = 0;
        for (int c = 0; c < 600; c++) begin
            bit we, clr, ack, full_old;
            we  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0 && m_r < m_w) begin
                int step;
                step = $urandom_range(1, 3);
                if (step > m_w - m_r) step = m_w - m_r;
                m_r += step;
            end
            wr_en = we; ovf_clr = clr; wsync_rptr = g(m_r);
            #1;
            ack = we && !m_full;
            chk("rnd_ack", wr_ack, ack);
            tick();
            full_old = m_full;
            m_w   += ack;
            m_lvl  = m_w - m_r;
            m_full = (m_lvl == 16);
            m_af   = (m_lvl >= 14);
            if (STICKY) m_ovf = (we && full_old) || (m_ovf && !clr);
            else        m_ovf = we && full_old;
            chk("rnd_wptr", wptr, g(m_w));
            chk("rnd_waddr", waddr, m_w % 16);
            chk("rnd_lvl", wr_level, m_lvl);
            chk("rnd_full", full, m_full);
            chk("rnd_af", almost_full, m_af);
            chk("rnd_ovf", ovf_err, m_ovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-domain pointer and status controller for the asynchronous FIFO, replacing the plain full-flag generator. It produces the RAM write address and the Gray write pointer that is sent to the read domain. It also derives a registered full flag, an occupancy level, a fixed-threshold almost-full flag and an overflow indication. All of these come from the read pointer after it has been synchronised into the write domain. It sits between the write client, the dual-port RAM and the read→write pointer synchroniser.

## Interface
- `DEPTH`, default 16: FIFO entries. Must be a power of two, ≥ 4. `AW = $clog2(DEPTH)`.
- `AF_THRESH`, default `DEPTH-2`: almost-full threshold, legal range 1..DEPTH.
- `w_clk`, in, 1: write clock. Single clock; every register is on its rising edge.
- `w_rst`, in, 1: reset, asynchronous and active-high.
- `wr_en`, in, 1: write request from the client.
- `wsync_rptr`, in, AW+1: read Gray pointer, already double-flopped into `w_clk`.
- `ovf_clr`, in, 1: clears the sticky overflow flag.
- `wr_ack`, out, 1: write accepted this cycle (gates the RAM write enable).
- `waddr`, out, AW: RAM write address.
- `wptr`, out, AW+1: registered Gray write pointer, sent to the read-domain synchroniser.
- `full`, out, 1: FIFO full.
- `almost_full`, out, 1: level ≥ `AF_THRESH`.
- `wr_level`, out, AW+1: entries occupied, 0..DEPTH, pessimistic.
- `ovf_err`, out, 1: write attempted while full.

## Operation
- State registers: `wbin` (AW+1 binary), `wptr`, `full`, `almost_full`, `wr_level`, `ovf_err`.
- Acceptance:
  - `wr_ack = wr_en & ~full`, combinational, using the registered `full`.
  - `wbin_next = wbin + wr_ack`.
  - `gray_next = (wbin_next >> 1) ^ wbin_next`.
- Address: `waddr = wbin[AW-1:0]`. The RAM writes `mem[waddr]` on the edge where `wr_ack` = 1.
- Full: `full_next = (gray_next == {~wsync_rptr[AW:AW-1], wsync_rptr[AW-2:0]})`.
- Level:
  - `rbin` = Gray-to-binary conversion of `wsync_rptr`.
  - `wr_level_next = wbin_next - rbin`, computed modulo 2^(AW+1), giving a result in 0..DEPTH.
- Almost-full: `almost_full_next = (wr_level_next >= AF_THRESH)`.
- Wrap-around: `wbin` rolls over from 2^(AW+1)-1 to 0 with no special handling. The MSB and Gray encoding keep full and level correct across the wrap.
- Write while full: `wr_ack` = 0, pointers hold, and the RAM is not written. `ovf_err` follows the Configuration section.
- Simultaneous write attempt and read-pointer advance while full: this cycle's write is rejected. `full` is re-evaluated at the same edge. The client must retry.
- All status outputs are conservative: they can report fuller than the true state, never emptier.

## Timing
- Reset: while `w_rst` is high, asynchronously and with no clock edge needed: `wbin`=0, `waddr`=0, `wptr`=0, `full`=0, `almost_full`=0, `wr_level`=0, `ovf_err`=0.
- `wr_ack` has zero latency: it is combinational from `wr_en` and `full`.
- `full`, `almost_full`, `wr_level` and `wptr` update on the same edge that registers the write which causes the change.
- Full-release latency after a read:
  - 2 `w_clk` cycles in the external synchroniser.
  - 1 cycle in this block.
- Reset asserted mid-burst: any in-flight write is discarded and the outputs return to their reset values immediately. The read side must be reset in the same reset event.

## Configuration
- Macro: `WPTR_FULL_OVF_STICKY_EN`.
- Defined:
  - `ovf_err` sets on any cycle with `wr_en & full`.
  - It stays set until `ovf_clr` is high at a clock edge, or until reset.
  - If set and clear occur in the same cycle, set wins.
- Not defined:
  - `ovf_err` is registered `wr_en & full` and pulses for one cycle per rejected write.
  - `ovf_clr` is ignored.

## Structure
- Shared package `afifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions, parameterised through the argument width.
  - `localparam` helpers for the AW computation.
- One sub-module, `gray2bin_conv`: a combinational XOR-prefix converter of width AW+1, used for `rbin`. The read-side empty controller reuses it.

## Test plan
All scenarios use DEPTH=16 and AF_THRESH=14.
- Reset, then 16 writes with `wsync_rptr`=0 → `full`=1 after the 16th edge, `wptr`=5'b11000, `wr_level`=16, `almost_full` rises after the 14th write.
- Full FIFO, `wr_en`=1 for 3 cycles → `wr_ack`=0 and pointers unchanged. With the macro: `ovf_err`=1 held, then cleared by an `ovf_clr` pulse. Without it: `ovf_err` pulses 3 cycles.
- Full FIFO, drive `wsync_rptr`=5'b11000 → `full`=0 and `wr_level`=0 one edge later.
- Same cycle: `wr_en`=1 while `full`=1, and `wsync_rptr` advances → `wr_ack`=0 that cycle, `full`=0 next cycle, next write accepted.
- Wrap: 32 writes, with `wsync_rptr` stepped to keep the level below 16 → `wbin` returns to 0 and `wptr`=0. With `wsync_rptr`=5'b11000 and 16 outstanding writes, `full`=1.
- After 5 writes, pulse `w_rst` between clock edges → all outputs are 0 before the next edge.
